// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and helpers for the load/store memory-stage controller.
package lsu_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned F3W  = 3;

    localparam logic [F3W-1:0] F3_B  = 3'b000;
    localparam logic [F3W-1:0] F3_H  = 3'b001;
    localparam logic [F3W-1:0] F3_W  = 3'b010;
    localparam logic [F3W-1:0] F3_BU = 3'b100;
    localparam logic [F3W-1:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        SPLIT,
        RESP
    } state_t;

    // Request as latched at acceptance.
    typedef struct packed {
        logic            we;
        logic [F3W-1:0]  func3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    function automatic logic is_legal(input logic [F3W-1:0] func3);
        logic r;
        case (func3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: r = 1'b1;
            default:                        r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_aligned(input logic [F3W-1:0] func3, input logic [1:0] lo);
        logic r;
        case (func3)
            F3_B, F3_BU: r = 1'b1;
            F3_H, F3_HU: r = ~lo[0];
            F3_W:        r = (lo == 2'b00);
            default:     r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] beat_count(input logic [F3W-1:0] func3);
        logic [2:0] r;
        case (func3)
            F3_H, F3_HU: r = 3'd2;
            F3_W:        r = 3'd4;
            default:     r = 3'd1;
        endcase
        return r;
    endfunction

    // Replicate store data across all byte lanes so the RAM can pick its lane.
    function automatic logic [XLEN-1:0] lane_replicate(input logic [F3W-1:0] func3,
                                                       input logic [XLEN-1:0] data);
        logic [XLEN-1:0] r;
        case (func3)
            F3_B, F3_BU: r = {4{data[7:0]}};
            F3_H, F3_HU: r = {2{data[15:0]}};
            default:     r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Pipeline request/response channel and byte-laned RAM port.
interface lsu_req_if;
    import lsu_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [F3W-1:0]       req_func3;
    logic [XLEN-1:0]      req_addr;
    logic [XLEN-1:0]      req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [XLEN-1:0]      resp_rdata;
    logic                 resp_err;

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface lsu_mem_if;
    import lsu_pkg::*;

    logic                 mem_we;
    logic [F3W-1:0]       mem_func3;
    logic [XLEN-1:0]      mem_address;
    logic [XLEN-1:0]      mem_wdata;
    logic [XLEN-1:0]      mem_rdata;

    modport master (
        output mem_we, mem_func3, mem_address, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_we, mem_func3, mem_address, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl_extend.sv
// Sign/zero extension of an assembled load value according to func3.
module lsu_extend
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] raw,
    input  logic [F3W-1:0]  func3,
    output logic [XLEN-1:0] ext_c
);

    always_comb begin
        ext_c = raw;
        case (func3)
            F3_B:    ext_c = {{24{raw[7]}}, raw[7:0]};
            F3_BU:   ext_c = {24'h0, raw[7:0]};
            F3_H:    ext_c = {{16{raw[15]}}, raw[15:0]};
            F3_HU:   ext_c = {16'h0, raw[15:0]};
            default: ext_c = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Memory-stage initiator: issues aligned accesses directly and splits
// misaligned ones into byte beats, returning one response per request.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input logic       clk,
    input logic       rst,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    state_t          state;
    req_t            lat;
    logic [1:0]      beat;
    logic [XLEN-1:0] asm_q;

    logic [XLEN-1:0] asm_c;
    logic [XLEN-1:0] ext_c;
    logic [1:0]      last_beat_c;
    logic [1:0]      next_beat_c;
    logic            req_err_c;

    // Current beat's byte merged into the assembly word, so the final beat
    // can be extended in the same cycle it arrives.
    always_comb begin
        asm_c                      = asm_q;
        asm_c[{beat, 3'b000} +: 8] = mem.mem_rdata[7:0];
        last_beat_c                = 2'(beat_count(lat.func3) - 3'd1);
        next_beat_c                = beat + 2'd1;
        req_err_c                  = !is_legal(req.req_func3) ||
                                     (!is_aligned(req.req_func3, req.req_addr[1:0]) &&
                                      !SPLIT_MISALIGNED);
    end

    lsu_extend u_extend (
        .raw   (asm_c),
        .func3 (lat.func3),
        .ext_c (ext_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            lat             <= '0;
            beat            <= '0;
            asm_q           <= '0;
            req.req_ready   <= 1'b1;
            req.resp_valid  <= 1'b0;
            req.resp_rdata  <= '0;
            req.resp_err    <= 1'b0;
            mem.mem_we      <= 1'b0;
            mem.mem_func3   <= '0;
            mem.mem_address <= '0;
            mem.mem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req.req_valid) begin
                        lat.we        <= req.req_we;
                        lat.func3     <= req.req_func3;
                        lat.addr      <= req.req_addr;
                        lat.wdata     <= req.req_wdata;
                        beat          <= '0;
                        asm_q         <= '0;
                        req.req_ready <= 1'b0;
                        if (req_err_c) begin
                            req.resp_valid <= 1'b1;
                            req.resp_err   <= 1'b1;
                            req.resp_rdata <= '0;
                            state          <= RESP;
                        end else if (is_aligned(req.req_func3, req.req_addr[1:0])) begin
                            mem.mem_we      <= req.req_we;
                            mem.mem_func3   <= req.req_func3;
                            mem.mem_address <= req.req_addr;
                            mem.mem_wdata   <= lane_replicate(req.req_func3, req.req_wdata);
                            state           <= ACCESS;
                        end else begin
                            mem.mem_we      <= req.req_we;
                            mem.mem_func3   <= req.req_we ? F3_B : F3_BU;
                            mem.mem_address <= req.req_addr;
                            mem.mem_wdata   <= {4{req.req_wdata[7:0]}};
                            state           <= SPLIT;
                        end
                    end
                end

                ACCESS: begin
                    mem.mem_we     <= 1'b0;
                    req.resp_rdata <= lat.we ? '0 : mem.mem_rdata;
                    req.resp_err   <= 1'b0;
                    req.resp_valid <= 1'b1;
                    state          <= RESP;
                end

                SPLIT: begin
                    asm_q <= asm_c;
                    if (beat == last_beat_c) begin
                        mem.mem_we     <= 1'b0;
                        req.resp_rdata <= lat.we ? '0 : ext_c;
                        req.resp_err   <= 1'b0;
                        req.resp_valid <= 1'b1;
                        state          <= RESP;
                    end else begin
                        beat            <= next_beat_c;
                        mem.mem_address <= lat.addr + XLEN'(next_beat_c);
                        mem.mem_wdata   <= {4{lat.wdata[{next_beat_c, 3'b000} +: 8]}};
                    end
                end

                RESP: begin
                    if (req.resp_ready) begin
                        req.resp_valid <= 1'b0;
                        req.resp_err   <= 1'b0;
                        req.req_ready  <= 1'b1;
                        state          <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: table vectors with a response
// scoreboard plus hand-written split, wrap, stall and reset sequences.
module tb_lsu_mem_ctrl;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_req_if rq ();
    lsu_mem_if mq ();
    lsu_req_if rq1 ();
    lsu_mem_if mq1 ();

    lsu_mem_ctrl #(.SPLIT_MISALIGNED(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .req (rq),
        .mem (mq)
    );

    lsu_mem_ctrl #(.SPLIT_MISALIGNED(1'b0)) dut_nosplit (
        .clk (clk),
        .rst (rst),
        .req (rq1),
        .mem (mq1)
    );

    assign mq1.mem_rdata = '0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nb;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          nb;
        logic        we;
    } exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    int total = 0;
    int bad   = 0;
    int wr_count = 0;
    exp_t  sb[$];
    beat_t beats[$];
    vec_t  vt[$];

    // Byte-addressed RAM model with combinational-style read refreshed each negedge.
    logic [7:0]  ram [bit [31:0]];
    logic [31:0] rw;

    function automatic logic [7:0] rd_byte(input bit [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) rw[8*k +: 8] = rd_byte(mq.mem_address + 32'(k));
        case (mq.mem_func3)
            3'b000:  mq.mem_rdata = {{24{rw[7]}}, rw[7:0]};
            3'b100:  mq.mem_rdata = {24'h0, rw[7:0]};
            3'b001:  mq.mem_rdata = {{16{rw[15]}}, rw[15:0]};
            3'b101:  mq.mem_rdata = {16'h0, rw[15:0]};
            default: mq.mem_rdata = rw;
        endcase
    end

    always @(posedge clk) begin
        if (mq.mem_we) begin
            int n;
            bit [31:0] a;
            n = (mq.mem_func3 == 3'b010) ? 4 : (mq.mem_func3 == 3'b001) ? 2 : 1;
            for (int k = 0; k < n; k++) begin
                a = mq.mem_address + 32'(k);
                ram[a] = mq.mem_wdata[{a[1:0], 3'b000} +: 8];
            end
            wr_count++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int stall);
        int cyc;
        int wr0;
        exp_t e;
        logic [31:0] r0;
        logic e0;
        beats.delete();
        cyc = 0;
        while (!rq.req_ready && cyc < 20) begin @(negedge clk); cyc++; end
        chk("req_ready_idle", 32'(rq.req_ready), 32'd1);
        wr0 = wr_count;
        rq.req_valid = 1'b1; rq.req_we = we; rq.req_func3 = f3;
        rq.req_addr = a; rq.req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        rq.req_valid = 1'b0;
        cyc = 1;
        while (!rq.resp_valid && cyc < 20) begin
            beats.push_back('{mq.mem_we, mq.mem_func3, mq.mem_address, mq.mem_wdata});
            @(negedge clk);
            cyc++;
        end
        chk("resp_valid_seen", 32'(rq.resp_valid), 32'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("latency", 32'(cyc), 32'(e.lat));
            chk("resp_rdata", rq.resp_rdata, e.rdata);
            chk("resp_err", 32'(rq.resp_err), 32'(e.err));
            chk("beats", 32'(beats.size()), 32'(e.nb));
            chk("writes", 32'(wr_count - wr0), e.we ? 32'(e.nb) : 32'd0);
        end
        chk("req_ready_in_resp", 32'(rq.req_ready), 32'd0);
        r0 = rq.resp_rdata;
        e0 = rq.resp_err;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            chk("stall_valid", 32'(rq.resp_valid), 32'd1);
            chk("stall_rdata", rq.resp_rdata, r0);
            chk("stall_err", 32'(rq.resp_err), 32'(e0));
            chk("stall_req_ready", 32'(rq.req_ready), 32'd0);
        end
        rq.resp_ready = 1'b1;
        @(negedge clk);
        rq.resp_ready = 1'b0;
        chk("resp_valid_drop", 32'(rq.resp_valid), 32'd0);
        chk("req_ready_back", 32'(rq.req_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input int stall);
        exp_t e;
        e.rdata = v.rdata; e.err = v.err; e.lat = v.lat; e.nb = v.nb; e.we = v.we;
        sb.push_back(e);
        do_req(v.we, v.f3, v.addr, v.wdata, stall);
    endtask

    task automatic chk_beat(input int i, input logic we, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
        if (i >= beats.size()) begin
            chk("beat_present", 32'(beats.size()), 32'(i + 1));
        end else begin
            chk("beat_we", 32'(beats[i].we), 32'(we));
            chk("beat_func3", 32'(beats[i].f3), 32'(f3));
            chk("beat_addr", beats[i].addr, a);
            if (we) chk("beat_wdata", beats[i].wdata, wd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        rq.req_valid = 0; rq.req_we = 0; rq.req_func3 = 0; rq.req_addr = 0;
        rq.req_wdata = 0; rq.resp_ready = 0;
        rq1.req_valid = 0; rq1.req_we = 0; rq1.req_func3 = 0; rq1.req_addr = 0;
        rq1.req_wdata = 0; rq1.resp_ready = 0;
        ram[32'h100] = 8'hEF; ram[32'h101] = 8'hBE; ram[32'h102] = 8'hAD; ram[32'h103] = 8'hDE;
        ram[32'h201] = 8'h11; ram[32'h202] = 8'h22; ram[32'h203] = 8'h34; ram[32'h204] = 8'h92;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(rq.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(rq.resp_valid), 32'd0);
        chk("rst_resp_rdata", rq.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(rq.resp_err), 32'd0);
        chk("rst_mem_we", 32'(mq.mem_we), 32'd0);
        chk("rst_mem_func3", 32'(mq.mem_func3), 32'd0);
        chk("rst_mem_address", mq.mem_address, 32'd0);
        chk("rst_mem_wdata", mq.mem_wdata, 32'd0);

        //            we  f3      addr          wdata         rdata         err lat nb
        vt.push_back('{0, 3'b010, 32'h100, 32'h0,         32'hDEADBEEF, 0, 2, 1});
        vt.push_back('{0, 3'b000, 32'h101, 32'h0,         32'hFFFFFFBE, 0, 2, 1});
        vt.push_back('{0, 3'b100, 32'h103, 32'h0,         32'h000000DE, 0, 2, 1});
        vt.push_back('{0, 3'b001, 32'h102, 32'h0,         32'hFFFFDEAD, 0, 2, 1});
        vt.push_back('{0, 3'b101, 32'h100, 32'h0,         32'h0000BEEF, 0, 2, 1});
        vt.push_back('{0, 3'b001, 32'h203, 32'h0,         32'hFFFF9234, 0, 3, 2});
        vt.push_back('{0, 3'b101, 32'h203, 32'h0,         32'h00009234, 0, 3, 2});
        vt.push_back('{0, 3'b010, 32'h201, 32'h0,         32'h92342211, 0, 5, 4});
        vt.push_back('{0, 3'b011, 32'h100, 32'h0,         32'h0,        1, 1, 0});
        vt.push_back('{1, 3'b110, 32'h100, 32'hFFFFFFFF,  32'h0,        1, 1, 0});
        vt.push_back('{0, 3'b111, 32'h101, 32'h0,         32'h0,        1, 1, 0});
        vt.push_back('{1, 3'b010, 32'h300, 32'h12345678,  32'h0,        0, 2, 1});
        vt.push_back('{1, 3'b001, 32'h301, 32'h0000CAFE,  32'h0,        0, 3, 2});
        vt.push_back('{0, 3'b101, 32'h301, 32'h0,         32'h0000CAFE, 0, 3, 2});
        vt.push_back('{0, 3'b010, 32'h300, 32'h0,         32'h12CAFE78, 0, 2, 1});
        vt.push_back('{0, 3'b001, 32'h302, 32'h0,         32'h000012CA, 0, 2, 1});
        for (int i = 0; i < vt.size(); i++) run_vec(vt[i], 0);

        // Aligned store byte: replicated lanes, single beat.
        run_vec('{1, 3'b000, 32'h102, 32'h000000A5, 32'h0, 0, 2, 1}, 0);
        chk_beat(0, 1'b1, 3'b000, 32'h102, 32'hA5A5A5A5);
        // Readback with a 3-cycle response stall.
        run_vec('{0, 3'b010, 32'h100, 32'h0, 32'hDEA5BEEF, 0, 2, 1}, 3);

        // Misaligned half loads as byte-unsigned beats.
        ram[32'h103] = 8'h34; ram[32'h104] = 8'h92;
        run_vec('{0, 3'b001, 32'h103, 32'h0, 32'hFFFF9234, 0, 3, 2}, 0);
        chk_beat(0, 1'b0, 3'b100, 32'h103, 32'h0);
        chk_beat(1, 1'b0, 3'b100, 32'h104, 32'h0);
        run_vec('{0, 3'b101, 32'h103, 32'h0, 32'h00009234, 0, 3, 2}, 0);

        // Misaligned word store wrapping past the top of the address space.
        run_vec('{1, 3'b010, 32'hFFFFFFFD, 32'h11223344, 32'h0, 0, 5, 4}, 0);
        chk_beat(0, 1'b1, 3'b000, 32'hFFFFFFFD, 32'h44444444);
        chk_beat(1, 1'b1, 3'b000, 32'hFFFFFFFE, 32'h33333333);
        chk_beat(2, 1'b1, 3'b000, 32'hFFFFFFFF, 32'h22222222);
        chk_beat(3, 1'b1, 3'b000, 32'h00000000, 32'h11111111);
        chk("wrap_ram_fffffffd", 32'(rd_byte(32'hFFFFFFFD)), 32'h44);
        chk("wrap_ram_ffffffff", 32'(rd_byte(32'hFFFFFFFF)), 32'h22);
        chk("wrap_ram_0", 32'(rd_byte(32'h0)), 32'h11);

        // Non-splitting instance: misaligned word load is an error with no RAM access.
        rq1.req_valid = 1'b1; rq1.req_we = 1'b0; rq1.req_func3 = 3'b010; rq1.req_addr = 32'h1;
        @(posedge clk);
        @(negedge clk);
        rq1.req_valid = 1'b0;
        chk("nosplit_valid", 32'(rq1.resp_valid), 32'd1);
        chk("nosplit_err", 32'(rq1.resp_err), 32'd1);
        chk("nosplit_rdata", rq1.resp_rdata, 32'd0);
        chk("nosplit_mem_we", 32'(mq1.mem_we), 32'd0);
        chk("nosplit_mem_addr", mq1.mem_address, 32'd0);
        rq1.resp_ready = 1'b1;
        @(negedge clk);
        rq1.resp_ready = 1'b0;
        chk("nosplit_drop", 32'(rq1.resp_valid), 32'd0);

        // Reset during beat 2 of a split word store: only beats 0-1 land.
        rq.req_valid = 1'b1; rq.req_we = 1'b1; rq.req_func3 = 3'b010;
        rq.req_addr = 32'h401; rq.req_wdata = 32'hA1B2C3D4;
        @(posedge clk);
        @(negedge clk);
        rq.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_beat2_we", 32'(mq.mem_we), 32'd1);
        chk("rst_beat2_addr", mq.mem_address, 32'h403);
        rst = 1'b1;
        #1;
        chk("rst_mid_mem_we", 32'(mq.mem_we), 32'd0);
        chk("rst_mid_req_ready", 32'(rq.req_ready), 32'd1);
        chk("rst_mid_resp_valid", 32'(rq.resp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ram_401", 32'(rd_byte(32'h401)), 32'hD4);
        chk("rst_ram_402", 32'(rd_byte(32'h402)), 32'hC3);
        chk("rst_ram_403", 32'(rd_byte(32'h403)), 32'h00);
        chk("rst_ram_404", 32'(rd_byte(32'h404)), 32'h00);
        chk("rst_after_resp_valid", 32'(rq.resp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
